// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: variable-latency data-memory bus between the MEM-stage LSU (master) and memory (slave).
interface mem_stage_lsu_if #(parameter int XLEN = 32);
  logic            dreq;
  logic            dwe;
  logic [XLEN-1:0] daddr;
  logic [3:0]      dbe;
  logic [XLEN-1:0] dwdata;
  logic            dgnt;
  logic            drvalid;
  logic [XLEN-1:0] drdata;
  modport master(output dreq, dwe, daddr, dbe, dwdata, input dgnt, drvalid, drdata);
  modport slave(input dreq, dwe, daddr, dbe, dwdata, output dgnt, drvalid, drdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM-stage load/store unit; issues bus requests, stalls the pipe, aligns load data.
module mem_stage_lsu #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  mem_stage_lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t          state;
  logic [1:0]      addr_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rdata_q;
  logic            op, st, ld, legal, mis, bad, go, act;
  logic [1:0]      sz, a;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [XLEN-1:0] ld_data;
  assign op    = MemReadM | MemWriteM;
  assign st    = MemWriteM;
  assign ld    = MemReadM & ~MemWriteM;
  assign sz    = Funct3M[1:0];
  assign a     = ALUResultM[1:0];
  // stores allow 000/001/010; loads additionally allow the unsigned 100/101
  assign legal = st ? (~Funct3M[2] & (sz != 2'd3)) : ((sz != 2'd3) & ~(Funct3M[2] & sz[1]));
  assign mis   = ((sz == 2'd1) & a[0]) | ((sz == 2'd2) & (a != 2'd0));
  assign bad   = op & (~legal | mis);
  assign go    = op & ~bad;
  // gating with rst makes the request drop the instant reset asserts
  assign act   = rst & go & ((state == IDLE) | (state == REQ));
  assign bus.dreq   = act;
  assign bus.dwe    = act & st;
  assign bus.daddr  = act ? {ALUResultM[XLEN-1:2], 2'b00} : '0;
  assign bus.dbe    = act ? ((sz == 2'd0) ? 4'b0001 << a : (sz == 2'd1) ? 4'b0011 << a : 4'b1111) : 4'b0000;
  assign bus.dwdata = act ? ((sz == 2'd0) ? {4{WriteDataM[7:0]}} : (sz == 2'd1) ? {2{WriteDataM[15:0]}} : WriteDataM) : '0;
  assign StallM     = rst & ((state == RESP) | (act & (ld | ~bus.dgnt)));
  assign MisalignM  = rst & bad & (state == IDLE);
  assign lb         = rdata_q[{addr_q, 3'b000} +: 8];
  assign lh         = rdata_q[{addr_q[1], 4'b0000} +: 16];
  assign ld_data    = (f3_q[1:0] == 2'd0) ? {{24{lb[7] & ~f3_q[2]}}, lb} :
                      (f3_q[1:0] == 2'd1) ? {{16{lh[15] & ~f3_q[2]}}, lh} : rdata_q;
  assign ReadDataM  = (rst && state == DONE) ? ld_data : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          if (ld) begin
            addr_q <= a;
            f3_q   <= Funct3M;
          end
          state <= (ld & bus.dgnt) ? RESP : bus.dgnt ? IDLE : REQ;
        end
        REQ:  if (bus.dgnt) state <= ld ? RESP : IDLE;
        RESP: if (bus.drvalid) begin
          rdata_q <= bus.drdata;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the RV32I pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Turns MEM-stage control, address and store data into a request on a variable-latency data-memory bus.
- Aligns and extends load data into ReadDataM for the MEM/WB register.
- Raises StallM to the hazard unit while an access is outstanding.

Parameters:
- XLEN, riscv_pkg::XLEN (32), datapath width; the only supported value is 32.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset
- MemReadM  input  1  load in MEM
- MemWriteM  input  1  store in MEM
- Funct3M  input  3  width/sign code
- ALUResultM  input  XLEN  byte address
- WriteDataM  input  XLEN  store source (rs2)
- ReadDataM  output  XLEN  aligned/extended load data, to MEM/WB
- StallM  output  1  hold IF..MEM; bubble into MEM/WB
- MisalignM  output  1  access suppressed (misaligned or illegal Funct3M)
- dreq  output  1  bus request
- dwe  output  1  write enable
- daddr  output  XLEN  word address, {ALUResultM[31:2],2'b00}
- dbe  output  4  byte enables
- dwdata  output  XLEN  lane-replicated store data
- dgnt  input  1  request accepted this cycle
- drvalid  input  1  load response valid
- drdata  input  XLEN  load response word

Behaviour:
- Reset values (rst low, asynchronous):
  - state=IDLE
  - ReadDataM, dreq, dwe, daddr, dbe, dwdata = 0
  - StallM=0, MisalignM=0
  - addr_q, f3_q, rdata_q = 0
- Op present: op = MemReadM|MemWriteM.
- Simultaneous MemReadM and MemWriteM: treated as a store.
- Legality:
  - Legal load Funct3M: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Legal store Funct3M: 000, 001, 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Illegal or misaligned op: no dreq; MisalignM=1 combinationally for that cycle; StallM=0; ReadDataM=0.
- Store formatting:
  - Byte enables: sb dbe=4'b0001<<addr[1:0]; sh dbe=4'b0011<<addr[1:0]; sw dbe=4'b1111.
  - dwdata: sb {4{wd[7:0]}}, sh {2{wd[15:0]}}, sw wd.
- Load formatting:
  - Byte/half lane selected by f3_q/addr_q[1:0] from rdata_q.
  - Signed loads sign-extend; lbu/lhu zero-extend.
  - Load dbe = store pattern for the same width.
- FSM (dreq, dwe, daddr, dbe, dwdata driven combinationally from the MEM inputs in IDLE/REQ):
  - IDLE:
    - Legal op: dreq=1.
    - Store with dgnt=1: completes this cycle, StallM=0, stay IDLE.
    - Store with dgnt=0: StallM=1, -> REQ.
    - Load: StallM=1; capture addr_q/f3_q. dgnt=1 -> RESP; dgnt=0 -> REQ.
  - REQ:
    - dreq held with identical address/data/dbe; inputs stay stable because StallM holds EX/MEM.
    - Store with dgnt: StallM=0, -> IDLE.
    - Load with dgnt: -> RESP, StallM=1.
  - RESP:
    - dreq=0, StallM=1.
    - On drvalid: rdata_q<=drdata, -> DONE.
  - DONE:
    - StallM=0; ReadDataM = formatted rdata_q.
    - The instruction advances at this clock edge; -> IDLE.
- Load latency: at least 2 cycles. Minimum is gnt in cycle 0, drvalid in cycle 1, data in DONE in cycle 2.
- Bus rules:
  - drvalid never arrives in the same cycle as the gnt that issued it.
  - At most one access outstanding.
  - drvalid in IDLE/REQ/DONE is ignored.
- Outside DONE, ReadDataM=0 except during a load in DONE.
- Reset mid-access: FSM returns to IDLE immediately; a late drvalid is ignored; dreq drops asynchronously.
- Back-to-back memory ops: the next op is evaluated in IDLE in the cycle after DONE or after a store completes. No op is ever issued twice.

Test Plan:
- sw addr=0x100, wd=0xDEADBEEF, dgnt same cycle -> dreq=1, dwe=1, daddr=0x100, dbe=1111, dwdata=0xDEADBEEF; StallM=0 throughout.
- sb addr=0x103, wd=0x000000A5, dgnt delayed 2 cycles -> dbe=1000, dwdata=0xA5A5A5A5, request held stable; StallM=1 for 2 cycles, then 0.
- lb addr=0x202, drdata=0x12F45678, gnt cycle 0, drvalid cycle 3 -> StallM high cycles 0-3; ReadDataM=0xFFFFFFF4 in cycle 4 with StallM=0. Same with lbu -> 0x000000F4.
- lh addr=0x201 and lw addr=0x302 -> no dreq, MisalignM=1, StallM=0, ReadDataM=0. Load with Funct3M=011 -> same response.
- rst asserted in RESP, drvalid arrives after release -> dreq/StallM=0 immediately, state IDLE, late response ignored, ReadDataM stays 0.
- lw then sw back-to-back, latency 1 -> exactly one request each; load data 0x89ABCDEF in DONE; store issued the following cycle.
